// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC job sequencer.
// Word width, tolerance, FSM encodings and the datapath init gain.
package cordic_pkg;

    localparam int CORDIC_WIDTH = 16;
    localparam int CORDIC_TOL   = 1;
    localparam int ITER_W       = 5;

    // CORDIC gain K in Q2.13, loaded into x_0 by the datapath on init
    localparam logic [CORDIC_WIDTH-1:0] K_INIT = 16'h136F;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_STOP  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

endpackage

// File: rtl/cordic_term_check.sv
// Combinational termination test for one CORDIC check pulse.
// Done when the next count reaches the limit or the angle error is within TOL.
module cordic_term_check
    import cordic_pkg::*;
#(
    parameter int WIDTH = CORDIC_WIDTH,
    parameter int TOL   = CORDIC_TOL
) (
    input  logic [WIDTH-1:0]  phi_r_i,
    input  logic [WIDTH-1:0]  phi_sum_i,
    input  logic [ITER_W-1:0] count_i,
    input  logic [ITER_W-1:0] max_iter_i,
    output logic              done_o
);

    localparam logic [WIDTH:0] TOL_W = (WIDTH+1)'(TOL);

    logic signed [WIDTH:0] err;
    logic        [WIDTH:0] err_abs;
    logic        [ITER_W:0] next_cnt;

    // Error is widened by one bit so the difference and its magnitude never wrap
    always_comb begin
        err      = $signed({phi_r_i[WIDTH-1], phi_r_i})
                 - $signed({phi_sum_i[WIDTH-1], phi_sum_i});
        err_abs  = err[WIDTH] ? $unsigned(-err) : $unsigned(err);
        next_cnt = {1'b0, count_i} + 1'b1;
        done_o   = (next_cnt >= {1'b0, max_iter_i}) || (err_abs <= TOL_W);
    end

endmodule

// File: rtl/cordic_sequencer.sv
// Job sequencer driving an iterative CORDIC controller/datapath pair.
// Accepts an angle, runs the controller until convergence or limit, returns cos/sin.
module cordic_sequencer
    import cordic_pkg::*;
#(
    parameter int WIDTH = CORDIC_WIDTH,
    parameter int TOL   = CORDIC_TOL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  phi_i,
    input  logic [ITER_W-1:0] max_iter_i,
    output logic              init_o,
    output logic              start_o,
    output logic              valid_o,
    input  logic              bussy_i,
    input  logic              check_for_termination_i,
    input  logic [WIDTH-1:0]  phi_sum_i,
    input  logic [WIDTH-1:0]  x_n_i,
    input  logic [WIDTH-1:0]  y_n_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  cos_o,
    output logic [WIDTH-1:0]  sin_o,
    output logic [ITER_W-1:0] iter_o
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  phi_q, phi_d;
    logic [ITER_W-1:0] max_iter_q, max_iter_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  cos_q, cos_d;
    logic [WIDTH-1:0]  sin_q, sin_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              in_ready_q, in_ready_d;
    logic              init_q, init_d;
    logic              start_q, start_d;
    logic              valid_q, valid_d;
    logic              out_valid_q, out_valid_d;
    logic              done;

    cordic_term_check #(
        .WIDTH (WIDTH),
        .TOL   (TOL)
    ) u_term (
        .phi_r_i    (phi_q),
        .phi_sum_i  (phi_sum_i),
        .count_i    (cnt_q),
        .max_iter_i (max_iter_q),
        .done_o     (done)
    );

    // Next-state and next-output logic; outputs decode the next state so they are registered
    always_comb begin
        state_d    = state_q;
        phi_d      = phi_q;
        max_iter_d = max_iter_q;
        cnt_d      = cnt_q;
        cos_d      = cos_q;
        sin_d      = sin_q;
        iter_d     = iter_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    phi_d      = phi_i;
                    max_iter_d = (max_iter_i == '0) ? ITER_W'(1) : max_iter_i;
                    cnt_d      = '0;
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                state_d = S_START;
            end
            S_START: begin
                if (bussy_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (check_for_termination_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (done || !bussy_i) begin
                        state_d = S_STOP;
                    end
                end else if (!bussy_i) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!bussy_i) begin
                    cos_d   = x_n_i;
                    sin_d   = y_n_i;
                    iter_d  = cnt_q;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        init_d      = (state_d == S_INIT);
        start_d     = (state_d == S_START);
        valid_d     = (state_d == S_STOP);
        out_valid_d = (state_d == S_OUT);
    end

    // State and registered outputs, synchronous reset discards any job in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phi_q       <= '0;
            max_iter_q  <= '0;
            cnt_q       <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
            iter_q      <= '0;
            in_ready_q  <= 1'b1;
            init_q      <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phi_q       <= phi_d;
            max_iter_q  <= max_iter_d;
            cnt_q       <= cnt_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            iter_q      <= iter_d;
            in_ready_q  <= in_ready_d;
            init_q      <= init_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign init_o      = init_q;
    assign start_o     = start_q;
    assign valid_o     = valid_q;
    assign out_valid_o = out_valid_q;
    assign cos_o       = cos_q;
    assign sin_o       = sin_q;
    assign iter_o      = iter_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Directed bench for cordic_sequencer; the CORDIC controller is played by the steps.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cordic_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] phi_i;
    logic [4:0]  max_iter_i;
    logic        init_o;
    logic        start_o;
    logic        valid_o;
    logic        bussy_i;
    logic        check_for_termination_i;
    logic [15:0] phi_sum_i;
    logic [15:0] x_n_i;
    logic [15:0] y_n_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] cos_o;
    logic [15:0] sin_o;
    logic [4:0]  iter_o;

    int total = 0;
    int bad   = 0;

    cordic_sequencer #(
        .WIDTH (16),
        .TOL   (1)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_valid_i              (in_valid_i),
        .in_ready_o              (in_ready_o),
        .phi_i                   (phi_i),
        .max_iter_i              (max_iter_i),
        .init_o                  (init_o),
        .start_o                 (start_o),
        .valid_o                 (valid_o),
        .bussy_i                 (bussy_i),
        .check_for_termination_i (check_for_termination_i),
        .phi_sum_i               (phi_sum_i),
        .x_n_i                   (x_n_i),
        .y_n_i                   (y_n_i),
        .out_valid_o             (out_valid_o),
        .out_ready_i             (out_ready_i),
        .cos_o                   (cos_o),
        .sin_o                   (sin_o),
        .iter_o                  (iter_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake a job in and walk it through INIT and START into RUN
    task automatic start_job(input logic [15:0] phi, input logic [4:0] mi);
        phi_i      = phi;
        max_iter_i = mi;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        chk("init_pulse", init_o, 1);
        chk("busy_not_ready", in_ready_o, 0);
        tick();
        chk("init_one_cycle", init_o, 0);
        chk("start_req", start_o, 1);
        tick();
        chk("start_held", start_o, 1);
        bussy_i = 1'b1;
        tick();
        chk("start_dropped", start_o, 0);
        chk("no_valid_in_run", valid_o, 0);
    endtask

    task automatic pulse();
        check_for_termination_i = 1'b1;
        tick();
        check_for_termination_i = 1'b0;
    endtask

    // Allow valid_o one more cycle beyond the pulse cycle (two in total)
    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid_o && n < 1) begin
            tick();
            n++;
        end
        chk(tag, valid_o, 1);
    endtask

    task automatic finish_job(input logic [15:0] xc, input logic [15:0] ys,
                              input logic [4:0] it);
        x_n_i   = xc;
        y_n_i   = ys;
        tick();
        chk("valid_held", valid_o, 1);
        bussy_i = 1'b0;
        tick();
        chk("out_valid", out_valid_o, 1);
        chk("valid_released", valid_o, 0);
        chk("cos", cos_o, xc);
        chk("sin", sin_o, ys);
        chk("iter", iter_o, it);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("out_done", out_valid_o, 0);
        chk("ready_again", in_ready_o, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid_i = 1'b0;
        phi_i = '0;
        max_iter_i = '0;
        bussy_i = 1'b0;
        check_for_termination_i = 1'b0;
        phi_sum_i = '0;
        x_n_i = '0;
        y_n_i = '0;
        out_ready_i = 1'b0;

        // Reset: three cycles high, then release
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_init", init_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_cos", cos_o, 0);
        chk("rst_sin", sin_o, 0);
        chk("rst_iter", iter_o, 0);

        // Converge at the first check pulse
        start_job(16'h1922, 5'd15);
        phi_sum_i = 16'h1922;
        pulse();
        wait_valid("conv_valid");
        finish_job(16'h0B50, 16'h0B4F, 5'd1);

        // Limit: error never within tolerance, four pulses
        start_job(16'h0000, 5'd4);
        phi_sum_i = 16'h0002;
        pulse(); tick();
        pulse(); tick();
        pulse(); tick();
        chk("lim_no_valid_3", valid_o, 0);
        pulse();
        wait_valid("lim_valid");
        finish_job(16'h1234, 16'h0567, 5'd4);

        // Wide error: 0x7FFF vs 0x8000 must not wrap to a small error
        start_job(16'h7FFF, 5'd3);
        phi_sum_i = 16'h8000;
        pulse(); tick();
        chk("wrap_no_stop", valid_o, 0);
        phi_sum_i = 16'h7FFE;
        pulse();
        wait_valid("tol_edge_valid");
        finish_job(16'h0001, 16'hFFFF, 5'd2);

        // Backpressure: result held while out_ready is low
        start_job(16'h0100, 5'd9);
        phi_sum_i = 16'h00FF;
        pulse();
        wait_valid("bp_valid");
        x_n_i = 16'h0AAA;
        y_n_i = 16'h0555;
        bussy_i = 1'b0;
        tick();
        x_n_i = 16'h7777;
        y_n_i = 16'h3333;
        for (int i = 0; i < 10; i++) begin
            in_valid_i = i[0];
            tick();
            chk("bp_out_valid", out_valid_o, 1);
            chk("bp_cos", cos_o, 16'h0AAA);
            chk("bp_sin", sin_o, 16'h0555);
            chk("bp_not_ready", in_ready_o, 0);
            chk("bp_no_init", init_o, 0);
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("bp_done", out_valid_o, 0);
        chk("bp_ready", in_ready_o, 1);
        tick();
        chk("bp_stay_idle", init_o, 0);

        // Reset in RUN after two pulses discards the job
        start_job(16'h0400, 5'd15);
        phi_sum_i = 16'h0000;
        pulse(); tick();
        pulse();
        chk("mid_no_valid", valid_o, 0);
        rst = 1'b1;
        tick();
        chk("mid_start", start_o, 0);
        chk("mid_valid", valid_o, 0);
        chk("mid_out_valid", out_valid_o, 0);
        rst = 1'b0;
        bussy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_result", out_valid_o, 0);
        end
        chk("mid_iter", iter_o, 0);
        chk("mid_ready", in_ready_o, 1);

        // max_iter 0 behaves as 1
        start_job(16'h0000, 5'd0);
        phi_sum_i = 16'h0100;
        pulse();
        wait_valid("mi0_valid");
        finish_job(16'h136F, 16'h0000, 5'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cordic_sequencer.md
CORDIC_SEQUENCER -- requirements
Module: cordic_sequencer

Interface
REQ-001 Parameters: WIDTH, 16, datapath word width (two's complement, Q2.13); TOL, 1, convergence tolerance in LSB.
REQ-002 Ports: clk  in  1  single clock, all logic rising-edge.
REQ-003 Ports: rst  in  1  synchronous, active-high reset.
REQ-004 Ports: in_valid_i  in  1 / in_ready_o  out  1  job-request handshake.
REQ-005 Ports: phi_i  in  WIDTH  target angle; max_iter_i  in  5  iteration limit.
REQ-006 Ports: init_o  out  1  one-cycle pulse; datapath loads x_0=K, y_0=0, n=0, phi_sum=0, sigma=+1.
REQ-007 Ports: start_o  out  1 / valid_o  out  1  run and terminate requests to the CORDIC controller.
REQ-008 Ports: bussy_i  in  1 / check_for_termination_i  in  1  status from the CORDIC controller.
REQ-009 Ports: phi_sum_i, x_n_i, y_n_i  in  WIDTH each  datapath register values.
REQ-010 Ports: out_valid_o  out  1 / out_ready_i  in  1  result handshake; cos_o, sin_o  out  WIDTH; iter_o  out  5.

Function
REQ-011 FSM states: S_IDLE, S_INIT, S_START, S_RUN, S_STOP, S_OUT; encodings come from the shared package.
REQ-012 S_IDLE: in_ready_o=1; on in_valid_i&in_ready_o, register phi_i and max_iter_i (0 replaced by 1), clear iter count, go to S_INIT.
REQ-013 S_INIT: init_o=1 for exactly one cycle, then S_START.
REQ-014 S_START: start_o=1 held until bussy_i=1 is sampled, then S_RUN (start_o low from that cycle on).
REQ-015 S_RUN: each cycle with check_for_termination_i=1 increments the iteration count by 1.
REQ-016 Termination at a check pulse: count+1 >= max_iter, or |phi_r - phi_sum_i| <= TOL; either condition moves to S_STOP.
REQ-017 Error arithmetic: subtraction in WIDTH+1 bits, absolute value in WIDTH+1 bits, no wrap-around.
REQ-018 S_STOP: valid_o=1 held until bussy_i=0 is sampled.
REQ-019 Leaving S_STOP registers x_n_i to cos_o, y_n_i to sin_o and the count to iter_o, then enters S_OUT.
REQ-020 valid_o is registered: it reaches the controller within 2 cycles of the check pulse, so the controller returns to idle before any write-back state.
REQ-021 S_OUT: out_valid_o=1, outputs stable until out_ready_i=1; then S_IDLE, with in_ready_o=1 on the next cycle.
REQ-022 in_ready_o=0 in every state except S_IDLE; in_valid_i outside S_IDLE is ignored.
REQ-023 A check pulse outside S_RUN is ignored; bussy_i falling in S_RUN without a stop request goes to S_STOP with the current count.

Reset
REQ-024 On rst=1 at a clock edge: state=S_IDLE; start_o, valid_o, init_o, out_valid_o=0; cos_o, sin_o, iter_o, internal phi, max_iter and count cleared.
REQ-025 in_ready_o=1 in the first cycle after rst deasserts.
REQ-026 Reset mid-operation discards the job and emits no result.

Structure
REQ-027 Shared package cordic_pkg holds WIDTH, TOL default, the FSM state encodings and the K init constant (0x136F in Q2.13).
REQ-028 Sub-module cordic_term_check is combinational: phi_r, phi_sum_i, count, max_iter in; done out. It is the only sub-module.

Verification
REQ-029 Reset: rst high 3 cycles then low -> all outputs 0 and in_ready_o=1 on the first cycle after release.
REQ-030 Converge: phi_i=0x1922, max_iter=15, model returns phi_sum=0x1922 at first check -> valid_o within 2 cycles, iter_o=1.
REQ-031 Limit: phi_i=0x0000, model phi_sum never within TOL, max_iter=4 -> 4 check pulses, valid_o after the 4th, iter_o=4.
REQ-032 Backpressure: out_ready_i low 10 cycles -> out_valid_o held and cos_o/sin_o stable; in_valid_i pulses are not accepted.
REQ-033 Reset in S_RUN after 2 check pulses -> start_o=valid_o=out_valid_o=0 the next cycle; no result is emitted.
REQ-034 max_iter_i=0 -> treated as 1; termination at the first check pulse, iter_o=1.
